// File: rtl/upg_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// upg_load_ctrl_pkg
// Shared definitions for the UART programmer (UPG) load controller:
//   - segment header byte values (HDR_INST, HDR_DATA, HDR_END)
//   - ZERO_WORD constant used to clear the write data word
//   - loader FSM state encoding (state_t) and a busy-state helper
// No ports; imported with `import upg_load_ctrl_pkg::*;`.
// -----------------------------------------------------------------------------
package upg_load_ctrl_pkg;

    localparam logic [7:0]  HDR_INST  = 8'h00;
    localparam logic [7:0]  HDR_DATA  = 8'h01;
    localparam logic [7:0]  HDR_END   = 8'hFF;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LEN_LO = 3'd2,
        S_LEN_HI = 3'd3,
        S_DATA   = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // A load is in flight in every state except the three resting states.
    function automatic logic is_busy(input state_t s);
        return !((s == S_IDLE) || (s == S_DONE) || (s == S_ERR));
    endfunction

endpackage

// File: rtl/upg_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// upg_load_ctrl_if
// Bundles the received byte stream and the upg_* memory write port.
//   rx_valid_i / rx_data_i : byte stream from the UART receiver
//   upg_rst_o              : 1 = CPU normal mode / loader idle, 0 = loading
//   upg_wen_o              : one-cycle write strobe
//   upg_sel_o              : target, 0 instruction ROM, 1 data RAM
//   upg_adr_o / upg_dat_o  : word address / write data
//   upg_done_o             : sticky load-complete flag
// Handshake: rx_valid_i is a one-cycle strobe with no ready/backpressure; the
// byte on rx_data_i is consumed in the cycle rx_valid_i is high or is lost.
// upg_wen_o is likewise a strobe with no ready; memories must accept it.
// Modports: master = loader side, slave = byte source / memory side.
// -----------------------------------------------------------------------------
interface upg_load_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              upg_rst_o;
    logic              upg_wen_o;
    logic              upg_sel_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;

    modport master (
        input  rx_valid_i, rx_data_i,
        output upg_rst_o, upg_wen_o, upg_sel_o, upg_adr_o, upg_dat_o, upg_done_o
    );

    modport slave (
        output rx_valid_i, rx_data_i,
        input  upg_rst_o, upg_wen_o, upg_sel_o, upg_adr_o, upg_dat_o, upg_done_o
    );
endinterface

// File: rtl/upg_load_ctrl_word_packer.sv
// -----------------------------------------------------------------------------
// upg_word_packer
// Packs bytes into a 32-bit little-endian word (first byte -> bits [7:0]).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : synchronous clear of byte counter and word
//   byte_valid   : accept byte_data into the current lane
//   byte_data    : incoming byte
//   word_o       : assembled word (held until overwritten or cleared)
//   word_ready_o : high in the cycle the 4th byte of a word is accepted
// -----------------------------------------------------------------------------
module upg_word_packer
    import upg_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt_q <= 2'd0;
            word_q     <= ZERO_WORD;
        end else if (byte_valid) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
            // 2-bit counter wraps to lane 0 for the next word on its own.
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = byte_valid && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/upg_load_ctrl.sv
// -----------------------------------------------------------------------------
// upg_load_ctrl
// UART programmer load sequencer. Parses segments (HDR, LEN_LO, LEN_HI, then
// 4*LEN data bytes), packs bytes into words and writes them to the instruction
// ROM (HDR 0x00) or data RAM (HDR 0x01) from word address 0. HDR 0xFF ends the
// load. The CPU is held out of normal mode (upg_rst_o=0) while loading.
// Ports:
//   clk, reset  : 10 MHz UPG clock, synchronous active-high reset
//   mode_i      : programming-mode request; rising edge starts a load,
//                 falling edge returns to idle (aborting any load in flight)
//   bus         : upg_load_ctrl_if.master (byte stream in, upg_* port out)
//   err_o       : sticky protocol error
//   busy_o      : load in flight
//   dbg_state_o : current FSM state
// Optional: define UPG_TIMEOUT_EN to abort to ERR when no byte arrives for
// TIMEOUT_CYC cycles in LEN_LO, LEN_HI or DATA. Undefined, the FSM waits.
// -----------------------------------------------------------------------------
module upg_load_ctrl
    import upg_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = 14
`ifdef UPG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 10_000_000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_i,
    upg_load_ctrl_if.master  bus,
    output logic             err_o,
    output logic             busy_o,
    output state_t           dbg_state_o
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state_q, state_n;
    logic              mode_q;
    logic              sel_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic              done_q;
    logic              err_q;

    logic              mode_rise;
    logic [15:0]       len_full;
    logic              last_word;
    logic              timeout_hit;
    logic              pk_valid;
    logic              pk_clear;
    logic              pk_ready;
    logic [31:0]       pk_word;

    assign mode_rise = mode_i && !mode_q;
    // Length as it will be once LEN_HI is captured this cycle.
    assign len_full  = {bus.rx_data_i, len_q[7:0]};
    assign last_word = ((17'(word_cnt_q) + 17'd1) == {1'b0, len_q});

    assign pk_valid = bus.rx_valid_i && (state_q == S_DATA);
    assign pk_clear = (state_q == S_LEN_HI);

    upg_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (pk_clear),
        .byte_valid   (pk_valid),
        .byte_data    (bus.rx_data_i),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

`ifdef UPG_TIMEOUT_EN
    logic [23:0] idle_cnt_q;
    logic        idle_counting;

    assign idle_counting = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                           (state_q == S_DATA);

    always_ff @(posedge clk) begin
        if (reset || !idle_counting || bus.rx_valid_i) begin
            idle_cnt_q <= 24'd0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 24'd1;
        end
    end

    assign timeout_hit = idle_counting && (idle_cnt_q == 24'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (mode_rise) state_n = S_HDR;
            end
            S_DONE, S_ERR: begin
                if (!mode_i) state_n = S_IDLE;
            end
            default: begin
                if (!mode_i) begin
                    state_n = S_IDLE;
                end else if (timeout_hit) begin
                    state_n = S_ERR;
                end else begin
                    case (state_q)
                        S_HDR: begin
                            if (bus.rx_valid_i) begin
                                if ((bus.rx_data_i == HDR_INST) || (bus.rx_data_i == HDR_DATA))
                                    state_n = S_LEN_LO;
                                else if (bus.rx_data_i == HDR_END)
                                    state_n = S_DONE;
                                else
                                    state_n = S_ERR;
                            end
                        end
                        S_LEN_LO: begin
                            if (bus.rx_valid_i) state_n = S_LEN_HI;
                        end
                        S_LEN_HI: begin
                            if (bus.rx_valid_i) begin
                                if (len_full == 16'd0)
                                    state_n = S_HDR;
                                else if ({1'b0, len_full} > MAX_WORDS)
                                    state_n = S_ERR;
                                else
                                    state_n = S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (pk_ready) state_n = S_WRITE;
                        end
                        S_WRITE: begin
                            // A byte here cannot be stored; treat as overrun.
                            if (bus.rx_valid_i)
                                state_n = S_ERR;
                            else if (last_word)
                                state_n = S_HDR;
                            else
                                state_n = S_DATA;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            // A switch already high when reset releases does not start a load.
            mode_q     <= 1'b1;
            sel_q      <= 1'b0;
            len_q      <= 16'd0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_i;

            if ((state_q == S_HDR) && (state_n == S_LEN_LO))
                sel_q <= bus.rx_data_i[0];

            if ((state_q == S_LEN_LO) && (state_n == S_LEN_HI))
                len_q[7:0] <= bus.rx_data_i;

            if ((state_q == S_LEN_HI) && (state_n == S_DATA)) begin
                len_q[15:8] <= bus.rx_data_i;
                word_cnt_q  <= '0;
            end

            if (state_q == S_WRITE)
                word_cnt_q <= word_cnt_q + ADDR_W'(1);

            if ((state_q == S_IDLE) && mode_rise) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if ((state_n == S_DONE) && (state_q != S_DONE))
                done_q <= 1'b1;
            if ((state_n == S_ERR) && (state_q != S_ERR))
                err_q <= 1'b1;
        end
    end

    assign bus.upg_rst_o  = (state_q == S_IDLE);
    assign bus.upg_wen_o  = (state_q == S_WRITE) && mode_i;
    assign bus.upg_sel_o  = sel_q;
    assign bus.upg_adr_o  = word_cnt_q;
    assign bus.upg_dat_o  = pk_word;
    assign bus.upg_done_o = done_q;
    assign err_o          = err_q;
    assign busy_o         = is_busy(state_q);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_upg_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_upg_load_ctrl
// Directed bench for upg_load_ctrl: segment loads into ROM and RAM, bad header,
// oversize and zero length, abort by mode_i, reset mid-load, byte overrun
// during the write cycle. A negedge monitor records every write strobe into a
// queue that is compared with the expected write queue at the end.
// -----------------------------------------------------------------------------
module tb_upg_load_ctrl;
    import upg_load_ctrl_pkg::*;

    localparam int AW = 14;

    logic   clk;
    logic   reset;
    logic   mode_i;
    logic   err_o;
    logic   busy_o;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // {sel, adr, dat}
    logic [AW+32:0] exp_q[$];
    logic [AW+32:0] got_q[$];

    upg_load_ctrl_if #(.ADDR_W(AW)) bus ();

    upg_load_ctrl #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode_i),
        .bus         (bus.master),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Write monitor
    always @(negedge clk) begin
        if (!reset && bus.upg_wen_o)
            got_q.push_back({bus.upg_sel_o, bus.upg_adr_o, bus.upg_dat_o});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic start_load();
        mode_i = 1'b1;
        tick();
    endtask

    task automatic end_load();
        mode_i = 1'b0;
        tick();
    endtask

    // Sends four bytes back-to-back; the write strobe must be up right after
    // the 4th byte is accepted. Leaves the WRITE cycle before returning.
    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic sel, input logic [AW-1:0] adr,
                             input string tag);
        logic [31:0] w;
        w = {b3, b2, b1, b0};
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        chk({tag, "_wen"}, 32'(bus.upg_wen_o), 32'd1);
        chk({tag, "_sel"}, 32'(bus.upg_sel_o), 32'(sel));
        chk({tag, "_adr"}, 32'(bus.upg_adr_o), 32'(adr));
        chk({tag, "_dat"}, bus.upg_dat_o, w);
        exp_q.push_back({sel, adr, w});
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rst"},  32'(bus.upg_rst_o),  32'd1);
        chk({tag, "_wen"},  32'(bus.upg_wen_o),  32'd0);
        chk({tag, "_sel"},  32'(bus.upg_sel_o),  32'd0);
        chk({tag, "_adr"},  32'(bus.upg_adr_o),  32'd0);
        chk({tag, "_dat"},  bus.upg_dat_o,       32'd0);
        chk({tag, "_done"}, 32'(bus.upg_done_o), 32'd0);
        chk({tag, "_err"},  32'(err_o),          32'd0);
        chk({tag, "_busy"}, 32'(busy_o),         32'd0);
        chk({tag, "_st"},   32'(dbg_state),      32'(S_IDLE));
    endtask

    initial begin
        int nwr;
        logic [AW+32:0] e, g;

        reset          = 1'b1;
        mode_i         = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        repeat (3) tick();
        chk_reset_values("por");
        reset = 1'b0;
        tick();

        // 1: two-word instruction segment then end marker
        start_load();
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_rst",  32'(bus.upg_rst_o), 32'd0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 14'd0, "t1_w0");
        send_word(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 14'd1, "t1_w1");
        send_byte(8'hFF);
        chk("t1_done", 32'(bus.upg_done_o), 32'd1);
        chk("t1_err",  32'(err_o), 32'd0);
        chk("t1_busy_done", 32'(busy_o), 32'd0);
        chk("t1_rst_done",  32'(bus.upg_rst_o), 32'd0);
        end_load();
        chk("t1_rst_idle",  32'(bus.upg_rst_o), 32'd1);
        chk("t1_done_held", 32'(bus.upg_done_o), 32'd1);

        // 2: one-word data segment
        start_load();
        chk("t2_done_clr", 32'(bus.upg_done_o), 32'd0);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b1, 14'd0, "t2_w0");
        send_byte(8'hFF);
        chk("t2_done", 32'(bus.upg_done_o), 32'd1);
        end_load();

        // 3: bad header, recovery, then a load whose data contains 0xFF
        start_load();
        nwr = got_q.size();
        send_byte(8'h7E);
        chk("t3_err",  32'(err_o), 32'd1);
        chk("t3_st",   32'(dbg_state), 32'(S_ERR));
        tick();
        chk("t3_nowr", 32'(got_q.size()), 32'(nwr));
        end_load();
        chk("t3_err_sticky", 32'(err_o), 32'd1);
        start_load();
        chk("t3_err_clr", 32'(err_o), 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'hFF, 8'h02, 8'h03, 8'h04, 1'b0, 14'd0, "t3_w0");
        send_byte(8'hFF);
        chk("t3_done", 32'(bus.upg_done_o), 32'd1);
        end_load();

        // 4: oversize length, then zero length
        start_load();
        nwr = got_q.size();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h40);
        chk("t4_big_err", 32'(err_o), 32'd1);
        chk("t4_big_st",  32'(dbg_state), 32'(S_ERR));
        end_load();
        start_load();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t4_zero_st",   32'(dbg_state), 32'(S_HDR));
        chk("t4_zero_busy", 32'(busy_o), 32'd1);
        send_byte(8'hFF);
        chk("t4_nowr",      32'(got_q.size()), 32'(nwr));
        chk("t4_done",      32'(bus.upg_done_o), 32'd1);
        end_load();

        // 5: abort by mode_i after two data bytes; then reset mid-DATA
        start_load();
        nwr = got_q.size();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        end_load();
        chk("t5_rst",  32'(bus.upg_rst_o), 32'd1);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_done", 32'(bus.upg_done_o), 32'd0);
        chk("t5_st",   32'(dbg_state), 32'(S_IDLE));
        repeat (2) tick();
        chk("t5_nowr", 32'(got_q.size()), 32'(nwr));
        start_load();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hFF);
        reset  = 1'b1;
        mode_i = 1'b0;
        tick();
        chk_reset_values("t5_mid");
        chk("t5_nowr2", 32'(got_q.size()), 32'(nwr));
        reset = 1'b0;
        tick();

        // 6: byte arriving during the write cycle
        start_load();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h04;
        tick();
        chk("t6_wen", 32'(bus.upg_wen_o), 32'd1);
        chk("t6_dat", bus.upg_dat_o, 32'h04030201);
        exp_q.push_back({1'b0, 14'd0, 32'h04030201});
        bus.rx_data_i = 8'h55;
        tick();
        bus.rx_valid_i = 1'b0;
        chk("t6_err", 32'(err_o), 32'd1);
        chk("t6_st",  32'(dbg_state), 32'(S_ERR));
        tick();
        chk("t6_wen_off", 32'(bus.upg_wen_o), 32'd0);
        end_load();

        // Scoreboard
        chk("wr_total", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk("wr_sel", 32'(g[AW+32]), 32'(e[AW+32]));
            chk("wr_adr", 32'(g[AW+31:32]), 32'(e[AW+31:32]));
            chk("wr_dat", g[31:0], e[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upg_load_ctrl.md
Name: upg_load_ctrl

Overview:
- Sequences the UART programmer path that fills the instruction ROM (prgrom) and the data RAM before the CPU runs.
- Consumes the received byte stream from the UART receiver and parses segment headers.
- Packs bytes into 32-bit little-endian words and drives the upg_* write port (reset, write enable, address, data, done) shared by IFetch and data memory.
- Holds the CPU out of normal mode until loading completes.

Parameters:
- ADDR_W, 14, word-address width of each target memory.
- TIMEOUT_CYC, 10_000_000, idle cycles tolerated mid-segment (optional feature only).

Ports:
- clk  in  1  system clock (10 MHz UPG domain).
- reset  in  1  synchronous, active-high.
- mode_i  in  1  programming-mode request (switch, already synchronised); rising edge starts a load.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i holds a new byte.
- rx_data_i  in  8  received byte.
- upg_rst_o  out  1  1 = CPU normal mode / loader idle; 0 = loading.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_sel_o  out  1  write target: 0 instruction ROM, 1 data RAM.
- upg_adr_o  out  ADDR_W  word address.
- upg_dat_o  out  32  write data.
- upg_done_o  out  1  load finished successfully; sticky.
- err_o  out  1  protocol error; sticky.
- busy_o  out  1  FSM not in IDLE, DONE or ERR.

Behaviour:
- Reset values: upg_rst_o=1, upg_wen_o=0, upg_sel_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, err_o=0, busy_o=0; state IDLE.
- Protocol:
  - Segments of the form HDR byte, LEN_LO, LEN_HI, then 4*LEN data bytes.
  - HDR values: 0x00 = instruction segment, 0x01 = data segment, 0xFF = end of load.
  - Every segment starts at word address 0 of its target.
- States:
  - IDLE: on a mode_i rising edge, go to HDR; upg_rst_o<=0; clear done and err.
  - HDR: on rx_valid_i:
    - 0x00/0x01: latch upg_sel_o, go to LEN_LO.
    - 0xFF: go to DONE.
    - Any other value: go to ERR.
  - LEN_LO: on rx_valid_i, capture len[7:0], go to LEN_HI.
  - LEN_HI: on rx_valid_i, capture len[15:8].
    - len==0: go to HDR.
    - len>2**ADDR_W: go to ERR.
    - Otherwise: clear word and byte counters, go to DATA.
  - DATA: on rx_valid_i, place the byte in lane byte_cnt (byte0 -> bits [7:0]) and increment byte_cnt (2 bits). On the 4th byte, go to WRITE.
  - WRITE: a single cycle with upg_wen_o=1, upg_adr_o=word_cnt and upg_dat_o = the assembled word. Next cycle, word_cnt increments. If word_cnt+1==len, go to HDR; else go to DATA.
  - DONE: upg_done_o=1, upg_rst_o=0 (kickOff asserted via done); stays until mode_i falls, then goes to IDLE with upg_rst_o=1 and upg_done_o held.
  - ERR: err_o=1, upg_wen_o never asserts; stays until mode_i falls, then goes to IDLE.
- Latency: the write strobe occurs exactly 1 cycle after the rx_valid_i of the 4th byte.
- A byte arriving during WRITE is impossible at the UART rate; if it does arrive, it is dropped and err_o is set (state ERR).
- mode_i falling in any busy state aborts to IDLE: no further writes, done stays 0, upg_rst_o returns to 1.
- The address never wraps; the len check guarantees word_cnt < 2**ADDR_W.
- A data byte equal to 0xFF is data, not an end marker; bytes are interpreted by state only.

Optional Feature:
- UPG_TIMEOUT_EN defined:
  - A 24-bit idle counter runs in LEN_LO, LEN_HI and DATA, and clears on each rx_valid_i.
  - When it reaches TIMEOUT_CYC, go to ERR.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Shared package/defines file (alongside includes/defines.v):
  - HDR_INST=8'h00, HDR_DATA=8'h01, HDR_END=8'hFF.
  - State encodings.
  - ZeroWord reused.
- One natural sub-module, upg_word_packer: byte lane insertion, byte counter, and a word-ready pulse.

Test Plan:
- Load {00, 02,00, 11,22,33,44, 55,66,77,88, FF} -> two writes: sel=0 adr=0 dat=0x44332211, then adr=1 dat=0x88776655; then done=1, err=0.
- Data segment {01, 01,00, EF,BE,AD,DE, FF} -> one write sel=1 adr=0 dat=0xDEADBEEF; done=1.
- Bad header 0x7E -> err=1, no wen; mode_i low then high -> err clears, new load accepted.
- Length 0x4001 (16385 words) -> ERR at LEN_HI, no writes; length 0 segment -> returns to HDR with no write.
- mode_i dropped after 2 of 4 data bytes -> IDLE, upg_rst_o=1, no write, done=0; reset mid-DATA -> all outputs return to reset values on the next clock.
- With UPG_TIMEOUT_EN and TIMEOUT_CYC=100: stall 100 cycles in DATA -> err=1; 99-cycle gaps -> load completes.
